input_debouncer: RTL and testbench

- Conditions raw asynchronous multi-bit inputs (board switches/buttons) into a clean, stable sample bus for the downstream change-detecting state machine.
- Synchronises each bit through a flop chain, then requires the whole word to hold a constant value for DEBOUNCE_CYCLES clocks before committing it.
- Presents the committed word on sample, with a one-cycle strobe whenever the committed value changes.
- Downstream consumes sample directly; the strobe is optional for it.

---
 rtl/input_debouncer.sv | 117 +++++++++++
 tb/tb_input_debouncer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// input_debouncer
//   Conditions raw asynchronous switch/button inputs into a clean committed
//   word. Each bit is synchronised through a flop chain. The synchronised word
//   must then hold one value for DEBOUNCE_CYCLES clocks before it is committed
//   to `sample`. `sample_strobe` pulses for one cycle on every committed change.
//   `busy` is high while a candidate word is settling.
//
//   Latency: raw_in is first captured at edge E0. `sample` then updates at
//   edge E0 + SYNC_STAGES + DEBOUNCE_CYCLES.

module input_debouncer #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,   // legal 2..4
  parameter int DEBOUNCE_CYCLES = 16   // legal >= 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] sample,
  output logic             sample_strobe,
  output logic             busy
);

  // The counter only ever reaches DEBOUNCE_CYCLES-1, so clog2 bits suffice.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,  // sample matches the synchronised input
    ST_SETTLE = 1'b1   // a candidate word is being timed for stability
  } state_t;

  // Synchroniser chain. Stage 0 captures raw_in; the last stage feeds the FSM.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  synced;

  // FSM state and registered outputs.
  state_t           state_q;
  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sample_q;
  logic             strobe_q;
  logic             busy_q;

  // Decision terms used by the FSM.
  logic input_moved;  // synchronised word differs from the committed word
  logic cand_moved;   // synchronised word bounced away from the candidate
  logic cnt_done;     // candidate has been stable for DEBOUNCE_CYCLES clocks

  assign synced      = sync_q[SYNC_STAGES-1];
  assign input_moved = (synced != sample_q);
  assign cand_moved  = (synced != cand_q);
  assign cnt_done    = (cnt_q == CNT_LAST);

  // Shift raw_in through the synchroniser chain, with no logic between stages.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain
  // into a single stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the synchroniser flops are cleared on reset too. That makes a
      // switch held through reset appear as a fresh change once reset is
      // released, so downstream always sees the initial setting.
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Two-state debounce FSM. All outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_STABLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;  // the strobe lives for exactly one cycle
      case (state_q)
        ST_STABLE: begin
          if (input_moved) begin
            cand_q  <= synced;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cand_moved) begin
            // Any bounce, on any bit, restarts timing for the whole word.
            cand_q <= synced;
            cnt_q  <= '0;
          end else if (!cnt_done) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            // Commit. A candidate that bounced back to the committed word
            // ends the settle quietly, without an update or a strobe.
            if (cand_q != sample_q) begin
              sample_q <= cand_q;
              strobe_q <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= ST_STABLE;
          end
        end
        default: state_q <= ST_STABLE;
      endcase
    end
  end

  assign sample        = sample_q;
  assign sample_strobe = strobe_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer
//   Table-driven vectors, hand-written reset sequences and random hold
//   segments. Every clock is compared against a reference model. The model
//   keeps the history of raw values seen by the debouncer. It commits a word
//   once the last DEBOUNCE_CYCLES+1 observations since settling began are all
//   equal.

module tb_input_debouncer;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] sample;
  logic             sample_strobe;
  logic             busy;

  input_debouncer #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .raw_in       (raw_in),
    .sample       (sample),
    .sample_strobe(sample_strobe),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int strobe_seen;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] hist[$];    // raw value captured at each edge, newest first
  logic [WIDTH-1:0] m_vals[$];  // words observed since settling began
  logic [WIDTH-1:0] m_sample;
  bit               m_settling;
  bit               m_strobe;

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i <= SYNC; i++) hist.push_back('0);
    m_vals     = {};
    m_sample   = '0;
    m_settling = 1'b0;
    m_strobe   = 1'b0;
  endfunction

  function automatic void model_edge(logic [WIDTH-1:0] raw);
    logic [WIDTH-1:0] seen;
    bit all_eq;
    hist.push_front(raw);
    seen = hist[SYNC];  // the word captured SYNC edges ago reaches the FSM now
    hist.delete(hist.size() - 1);
    m_strobe = 1'b0;
    if (!m_settling) begin
      if (seen != m_sample) begin
        m_settling = 1'b1;
        m_vals     = {};
        m_vals.push_back(seen);
      end
    end else begin
      m_vals.push_back(seen);
      if (m_vals.size() > DEB + 1) m_vals.delete(0);
      if (m_vals.size() == DEB + 1) begin
        all_eq = 1'b1;
        foreach (m_vals[i]) if (m_vals[i] != seen) all_eq = 1'b0;
        if (all_eq) begin
          if (seen != m_sample) begin
            m_sample = seen;
            m_strobe = 1'b1;
          end
          m_settling = 1'b0;
          m_vals     = {};
        end
      end
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock. Update the model, then compare all outputs 1 ns later.
  task automatic step();
    @(posedge clk);
    if (!reset) model_edge(raw_in);
    #1;
    if (sample_strobe === 1'b1) strobe_seen++;
    check("model.sample", 32'(sample), 32'(m_sample));
    check("model.busy", 32'(busy), 32'(m_settling));
    check("model.strobe", 32'(sample_strobe), 32'(m_strobe));
  endtask

  // Assert reset away from the clock edge and check that it clears the
  // outputs immediately.
  task automatic pulse_reset(input int edges);
    reset = 1'b1;
    model_reset();
    #1;
    check("rst.sample", 32'(sample), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.strobe", 32'(sample_strobe), 32'h0);
    repeat (edges) step();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WIDTH-1:0] raw;
    int               hold;
    logic [WIDTH-1:0] exp_sample;
    logic             exp_busy;
    int               exp_strobes;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [WIDTH-1:0] r, int h, logic [WIDTH-1:0] s,
                              logic b, int n);
    vec_t v;
    v.raw = r; v.hold = h; v.exp_sample = s; v.exp_busy = b; v.exp_strobes = n;
    return v;
  endfunction

  initial begin
    // idle after reset
    vecs.push_back(mk(4'h0, 40, 4'h0, 1'b0, 0));
    // 3/1 bouncing every 5 cycles: no commit
    vecs.push_back(mk(4'h3, 5, 4'h0, 1'b1, 0));
    vecs.push_back(mk(4'h1, 5, 4'h0, 1'b1, 0));
    vecs.push_back(mk(4'h3, 5, 4'h0, 1'b1, 0));
    vecs.push_back(mk(4'h1, 5, 4'h0, 1'b1, 0));
    vecs.push_back(mk(4'h3, 5, 4'h0, 1'b1, 0));
    vecs.push_back(mk(4'h1, 5, 4'h0, 1'b1, 0));
    // final hold of 3: one edge short of commit, then the commit edge
    vecs.push_back(mk(4'h3, 18, 4'h0, 1'b1, 0));
    vecs.push_back(mk(4'h3, 1, 4'h3, 1'b0, 1));
    // clean change to A: 18 edges latency, single strobe
    vecs.push_back(mk(4'hA, 18, 4'h3, 1'b1, 0));
    vecs.push_back(mk(4'hA, 1, 4'hA, 1'b0, 1));
    vecs.push_back(mk(4'hA, 5, 4'hA, 1'b0, 0));
    // commit 5, glitch to 7 for 6 cycles, return to 5: no strobe
    vecs.push_back(mk(4'h5, 25, 4'h5, 1'b0, 1));
    vecs.push_back(mk(4'h7, 6, 4'h5, 1'b1, 0));
    vecs.push_back(mk(4'h5, 30, 4'h5, 1'b0, 0));

    strobe_seen = 0;
    raw_in = '0;
    reset  = 1'b1;
    model_reset();
    repeat (3) step();
    check("init.sample", 32'(sample), 32'h0);
    check("init.busy", 32'(busy), 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      raw_in = vecs[i].raw;
      strobe_seen = 0;
      repeat (vecs[i].hold) step();
      check($sformatf("vec%0d.sample", i), 32'(sample), 32'(vecs[i].exp_sample));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d.strobes", i), 32'(strobe_seen), 32'(vecs[i].exp_strobes));
    end

    // C held through reset: committed 18 edges after the first capture
    raw_in = 4'hC;
    pulse_reset(3);
    strobe_seen = 0;
    repeat (18) step();
    check("hold_rst.sample_pre", 32'(sample), 32'h0);
    check("hold_rst.busy_pre", 32'(busy), 32'h1);
    check("hold_rst.strobes_pre", 32'(strobe_seen), 32'h0);
    step();
    check("hold_rst.sample", 32'(sample), 32'hC);
    check("hold_rst.strobe", 32'(sample_strobe), 32'h1);
    step();
    check("hold_rst.strobe_off", 32'(sample_strobe), 32'h0);

    // settling toward 9, reset when the counter is at 10, then settle again
    raw_in = 4'h9;
    repeat (13) step();
    check("mid.sample_pre", 32'(sample), 32'hC);
    check("mid.busy_pre", 32'(busy), 32'h1);
    pulse_reset(1);
    strobe_seen = 0;
    repeat (18) step();
    check("mid.sample_pre_commit", 32'(sample), 32'h0);
    check("mid.strobes_pre_commit", 32'(strobe_seen), 32'h0);
    step();
    check("mid.sample", 32'(sample), 32'h9);
    check("mid.strobe", 32'(sample_strobe), 32'h1);

    // random hold segments with occasional reset pulses
    for (int seg = 0; seg < 200; seg++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset(int'($urandom_range(1, 3)));
      raw_in = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 24)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
